// File: rtl/pingpong_block_ram_if.sv
// Loader, commit and dual read-port signals of the ping-pong table RAM.
// Reads are enable-qualified with a valid pulse; the loader never backpressures.
`timescale 1ns/1ps
interface pingpong_block_ram_if #(
  parameter int C_DATA_WIDTH    = 8,
  parameter int C_ADDRESS_WIDTH = 8
);
  logic                       wr_restart;
  logic                       wr_en;
  logic [C_DATA_WIDTH-1:0]    wr_data;
  logic                       wr_full;
  logic [C_ADDRESS_WIDTH:0]   wr_count;
  logic                       commit;
  logic                       active_bank;
  logic [C_ADDRESS_WIDTH:0]   size;
  logic                       reA;
  logic [C_ADDRESS_WIDTH-1:0] addrA;
  logic [C_DATA_WIDTH-1:0]    qA;
  logic                       validA;
  logic                       reB;
  logic [C_ADDRESS_WIDTH-1:0] addrB;
  logic [C_DATA_WIDTH-1:0]    qB;
  logic                       validB;

  modport master (
    output wr_restart, wr_en, wr_data, commit, reA, addrA, reB, addrB,
    input  wr_full, wr_count, active_bank, size, qA, validA, qB, validB
  );

  modport slave (
    input  wr_restart, wr_en, wr_data, commit, reA, addrA, reB, addrB,
    output wr_full, wr_count, active_bank, size, qA, validA, qB, validB
  );
endinterface

// File: rtl/pingpong_block_ram.sv
// Double-buffered table RAM: loader fills the shadow bank, commit swaps banks atomically.
// Read latency 1 or 2 cycles, one read per port per cycle; loader drops or wraps when full.
`timescale 1ns/1ps
module pingpong_block_ram #(
  parameter int C_DATA_WIDTH    = 8,
  parameter int C_ADDRESS_WIDTH = 8,
  parameter int C_READ_LATENCY  = 1,
  parameter int C_WRAP          = 0
) (
  input  logic                 clk,
  input  logic                 resetn,
  pingpong_block_ram_if.slave  bus
);

  localparam int D = 2 ** C_ADDRESS_WIDTH;
  localparam logic [C_ADDRESS_WIDTH:0] DEPTH = {1'b1, {C_ADDRESS_WIDTH{1'b0}}};

  logic [C_DATA_WIDTH-1:0]    mem [0:2*D-1];
  logic [C_ADDRESS_WIDTH-1:0] wr_ptr;
  logic [C_ADDRESS_WIDTH:0]   wr_count;
  logic [C_ADDRESS_WIDTH:0]   count_next;
  logic [C_ADDRESS_WIDTH:0]   size;
  logic                       active_bank;
  logic                       wr_full;
  logic                       wr_accept;

  assign wr_full    = (C_WRAP == 0) && (wr_count == DEPTH);
  assign wr_accept  = bus.wr_en && !bus.wr_restart && ((C_WRAP != 0) || !wr_full);
  // Count including this cycle's write, so a commit publishes it in size.
  assign count_next = (wr_accept && (wr_count != DEPTH)) ? wr_count + 1'b1 : wr_count;

  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem[{~active_bank, wr_ptr}] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr      <= '0;
      wr_count    <= '0;
      active_bank <= 1'b0;
      size        <= '0;
    end else if (bus.commit) begin
      active_bank <= ~active_bank;
      size        <= count_next;
      wr_ptr      <= '0;
      wr_count    <= '0;
    end else if (bus.wr_restart) begin
      wr_ptr      <= '0;
      wr_count    <= '0;
    end else begin
      if (wr_accept) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      wr_count <= count_next;
    end
  end

  logic [1:0]                        re;
  logic [1:0][C_ADDRESS_WIDTH-1:0]   raddr;
  logic [1:0][C_DATA_WIDTH-1:0]      q;
  logic [1:0]                        vld;

  assign re    = {bus.reB, bus.reA};
  assign raddr = {bus.addrB, bus.addrA};

  for (genvar p = 0; p < 2; p++) begin : g_port
    logic [C_DATA_WIDTH-1:0] rd_dat;
    logic                    rd_vld;

    // Reads only ever address the active bank, so they never see the loader.
    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        rd_dat <= '0;
        rd_vld <= 1'b0;
      end else begin
        rd_vld <= re[p];
        if (re[p]) begin
          rd_dat <= mem[{active_bank, raddr[p]}];
        end
      end
    end

    if (C_READ_LATENCY == 2) begin : g_lat2
      logic [C_DATA_WIDTH-1:0] out_dat;
      logic                    out_vld;

      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          out_dat <= '0;
          out_vld <= 1'b0;
        end else begin
          out_vld <= rd_vld;
          if (rd_vld) begin
            out_dat <= rd_dat;
          end
        end
      end

      assign q[p]   = out_dat;
      assign vld[p] = out_vld;
    end else begin : g_lat1
      assign q[p]   = rd_dat;
      assign vld[p] = rd_vld;
    end
  end

  assign bus.qA          = q[0];
  assign bus.validA      = vld[0];
  assign bus.qB          = q[1];
  assign bus.validB      = vld[1];
  assign bus.wr_full     = wr_full;
  assign bus.wr_count    = wr_count;
  assign bus.active_bank = active_bank;
  assign bus.size        = size;

endmodule

// File: tb/tb_pingpong_block_ram.sv
// Bench for two depth-4 instances: drop policy with latency 1, wrap policy with latency 2.
// Read expectations carry data and due cycle; the negedge monitor pops them on valid.
`timescale 1ns/1ps
module tb_pingpong_block_ram;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       wr_restart = 1'b0, wr_en = 1'b0, commit = 1'b0, reA = 1'b0, reB = 1'b0;
  logic [7:0] wr_data = '0;
  logic [1:0] addrA = '0, addrB = '0;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] cyc = '0;

  typedef struct packed {
    logic [7:0]  d;
    logic [31:0] due;
  } exp_t;

  // 0: dut0 A, 1: dut0 B, 2: dut1 A, 3: dut1 B
  exp_t sb [4][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pingpong_block_ram_if #(.C_DATA_WIDTH(8), .C_ADDRESS_WIDTH(2)) b0 ();
  pingpong_block_ram_if #(.C_DATA_WIDTH(8), .C_ADDRESS_WIDTH(2)) b1 ();

  assign b0.wr_restart = wr_restart;  assign b1.wr_restart = wr_restart;
  assign b0.wr_en      = wr_en;       assign b1.wr_en      = wr_en;
  assign b0.wr_data    = wr_data;     assign b1.wr_data    = wr_data;
  assign b0.commit     = commit;      assign b1.commit     = commit;
  assign b0.reA        = reA;         assign b1.reA        = reA;
  assign b0.addrA      = addrA;       assign b1.addrA      = addrA;
  assign b0.reB        = reB;         assign b1.reB        = reB;
  assign b0.addrB      = addrB;       assign b1.addrB      = addrB;

  pingpong_block_ram #(
    .C_DATA_WIDTH(8), .C_ADDRESS_WIDTH(2), .C_READ_LATENCY(1), .C_WRAP(0)
  ) u_dut0 (.clk(clk), .resetn(resetn), .bus(b0));

  pingpong_block_ram #(
    .C_DATA_WIDTH(8), .C_ADDRESS_WIDTH(2), .C_READ_LATENCY(2), .C_WRAP(1)
  ) u_dut1 (.clk(clk), .resetn(resetn), .bus(b1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, want);
    end
  endtask

  task automatic mon(input int p, input logic v, input logic [7:0] q);
    exp_t e;
    if (v) begin
      if (sb[p].size() == 0) begin
        chk($sformatf("port%0d_spurious_valid", p), {31'd0, v}, 32'd0);
      end else begin
        e = sb[p].pop_front();
        chk($sformatf("port%0d_data", p), {24'd0, q}, {24'd0, e.d});
        chk($sformatf("port%0d_latency", p), cyc, e.due);
      end
    end else if (sb[p].size() != 0 && sb[p][0].due < cyc) begin
      e = sb[p].pop_front();
      chk($sformatf("port%0d_missing_valid", p), {31'd0, v}, 32'd1);
    end
  endtask

  always @(negedge clk) begin
    if (resetn) begin
      mon(0, b0.validA, b0.qA);
      mon(1, b0.validB, b0.qB);
      mon(2, b1.validA, b1.qA);
      mon(3, b1.validB, b1.qB);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    wr_en = 1'b0; wr_restart = 1'b0; commit = 1'b0; reA = 1'b0; reB = 1'b0;
  endtask

  task automatic set_wr(input logic [7:0] d);
    wr_en = 1'b1;
    wr_data = d;
  endtask

  task automatic set_rd(input logic [1:0] aa, input logic [1:0] ab,
                        input logic [7:0] d0a, input logic [7:0] d0b,
                        input logic [7:0] d1a, input logic [7:0] d1b);
    reA = 1'b1; addrA = aa;
    reB = 1'b1; addrB = ab;
    sb[0].push_back('{d: d0a, due: cyc + 1});
    sb[1].push_back('{d: d0b, due: cyc + 1});
    sb[2].push_back('{d: d1a, due: cyc + 2});
    sb[3].push_back('{d: d1b, due: cyc + 2});
  endtask

  task automatic chk_ld(input string t, input int cnt);
    chk({t, "_count0"}, 32'(b0.wr_count), 32'(cnt));
    chk({t, "_count1"}, 32'(b1.wr_count), 32'(cnt));
    chk({t, "_full0"}, {31'd0, b0.wr_full}, {31'd0, cnt == 4});
    chk({t, "_full1"}, {31'd0, b1.wr_full}, 32'd0);
  endtask

  task automatic chk_bank(input string t, input logic act, input int sz);
    chk({t, "_bank0"}, {31'd0, b0.active_bank}, {31'd0, act});
    chk({t, "_bank1"}, {31'd0, b1.active_bank}, {31'd0, act});
    chk({t, "_size0"}, 32'(b0.size), 32'(sz));
    chk({t, "_size1"}, 32'(b1.size), 32'(sz));
  endtask

  task automatic chk_reset(input string t);
    chk({t, "_bank0"}, {31'd0, b0.active_bank}, 32'd0);
    chk({t, "_bank1"}, {31'd0, b1.active_bank}, 32'd0);
    chk({t, "_size0"}, 32'(b0.size), 32'd0);
    chk({t, "_size1"}, 32'(b1.size), 32'd0);
    chk({t, "_count0"}, 32'(b0.wr_count), 32'd0);
    chk({t, "_count1"}, 32'(b1.wr_count), 32'd0);
    chk({t, "_full0"}, {31'd0, b0.wr_full}, 32'd0);
    chk({t, "_qA0"}, 32'(b0.qA), 32'd0);
    chk({t, "_qB0"}, 32'(b0.qB), 32'd0);
    chk({t, "_qA1"}, 32'(b1.qA), 32'd0);
    chk({t, "_qB1"}, 32'(b1.qB), 32'd0);
    chk({t, "_vld0"}, {30'd0, b0.validA, b0.validB}, 32'd0);
    chk({t, "_vld1"}, {30'd0, b1.validA, b1.validB}, 32'd0);
  endtask

  task automatic drain();
    clr();
    repeat (4) tick();
  endtask

  initial begin
    logic [7:0] t1 [4];
    logic [7:0] d;
    t1 = '{8'h11, 8'h22, 8'h33, 8'h44};

    #12;
    chk_reset("por");
    @(negedge clk);
    resetn = 1'b1;
    tick();

    // Basic load of bank 1 and first read
    for (int i = 0; i < 4; i++) begin
      set_wr(t1[i]); tick(); clr();
    end
    chk_ld("t1_load", 4);
    commit = 1'b1; tick(); clr();
    chk_bank("t1_commit", 1'b1, 4);
    chk_ld("t1_commit", 0);
    set_rd(2'd2, 2'd0, 8'h33, 8'h11, 8'h33, 8'h11);
    tick();
    drain();

    // Overflow: drop policy stops at 4, wrap policy overwrites from 0
    for (int i = 1; i <= 6; i++) begin
      set_wr(8'(i)); tick(); clr();
      chk_ld($sformatf("t2_w%0d", i), (i < 4) ? i : 4);
    end
    commit = 1'b1; tick(); clr();
    chk_bank("t2_commit", 1'b0, 4);
    for (int a = 0; a < 4; a++) begin
      d = (a == 0) ? 8'd5 : (a == 1) ? 8'd6 : 8'(a + 1);
      set_rd(2'(a), 2'(a), 8'(a + 1), 8'(a + 1), d, d);
      tick();
    end
    drain();

    // Fill bank 1 with 0x55, then stream 0xAA into bank 0 under continuous reads
    for (int i = 0; i < 4; i++) begin
      set_wr(8'h55); tick(); clr();
    end
    commit = 1'b1; tick(); clr();
    chk_bank("t4_pre", 1'b1, 4);
    for (int k = 0; k < 8; k++) begin
      d = (k <= 3) ? 8'h55 : 8'hAA;
      set_rd(2'(k), 2'(k + 1), d, d, d, d);
      if (k < 4) set_wr(8'hAA);
      if (k == 3) commit = 1'b1;
      tick();
      clr();
    end
    chk_bank("t4_commit", 1'b0, 4);
    chk_ld("t4_commit", 0);
    drain();

    // Commit together with restart and a write: write discarded, pre-write size
    set_wr(8'h01); tick(); clr();
    set_wr(8'h02); tick(); clr();
    chk_ld("t5_load", 2);
    set_wr(8'h77); wr_restart = 1'b1; commit = 1'b1; tick(); clr();
    chk_bank("t5_commit", 1'b1, 2);
    chk_ld("t5_commit", 0);
    set_rd(2'd0, 2'd2, 8'h01, 8'h55, 8'h01, 8'h55);
    tick();
    drain();

    // Back-to-back empty commits
    commit = 1'b1; tick();
    chk_bank("bb_first", 1'b0, 0);
    tick(); clr();
    chk_bank("bb_second", 1'b1, 0);

    // Restart rewinds the pointer; addr beyond size returns stale content
    set_wr(8'h99); tick(); clr();
    chk_ld("rs_load", 1);
    wr_restart = 1'b1; tick(); clr();
    chk_ld("rs_restart", 0);
    set_wr(8'h42); tick(); clr();
    commit = 1'b1; tick(); clr();
    chk_bank("rs_commit", 1'b0, 1);
    set_rd(2'd0, 2'd1, 8'h42, 8'hAA, 8'h42, 8'hAA);
    tick();
    drain();
    chk("sb_drained", 32'(sb[0].size() + sb[1].size() + sb[2].size() + sb[3].size()), 32'd0);

    // Asynchronous reset in the middle of a load
    set_wr(8'h10); tick(); set_wr(8'h20); tick(); clr();
    commit = 1'b1; tick(); clr();
    chk_bank("ar_pre", 1'b1, 2);
    set_wr(8'h30); tick(); set_wr(8'h40); tick();
    chk_ld("ar_pre", 2);
    #3;
    resetn = 1'b0;
    #1;
    chk_reset("async");
    clr();
    @(negedge clk);
    resetn = 1'b1;
    tick();
    chk_bank("ar_post", 1'b0, 0);
    chk_ld("ar_post", 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
